// File: rtl/s3_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : s3_wr_arbiter
//  Brief    : Slave-3 write-path arbiter. Round-robin AW grant among the
//             masters, then in-order W-mux and B-demux steering through two
//             small index FIFOs. Control only; payload muxing is external.
//  Options  : S3_WR_ARB_QOS_EN - adds m_awqos; highest QoS wins, ties are
//             broken round-robin from the pointer.
//  Revision : 1.0  initial release
// ============================================================================
module s3_wr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int SEL_W           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [NUM_MASTERS-1:0]             m_awvalid,
`ifdef S3_WR_ARB_QOS_EN
    input  logic [NUM_MASTERS*4-1:0]           m_awqos,
`endif
    output logic [NUM_MASTERS-1:0]             m_awready,
    output logic                               s_awvalid,
    input  logic                               s_awready,
    output logic [SEL_W-1:0]                   aw_sel,
    output logic [SEL_W-1:0]                   w_sel,
    output logic                               w_sel_valid,
    input  logic                               s_wvalid,
    input  logic                               s_wready,
    input  logic                               s_wlast,
    output logic [SEL_W-1:0]                   b_sel,
    output logic                               b_sel_valid,
    input  logic                               s_bvalid,
    input  logic                               s_bready,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [SEL_W:0]     c_NUM_M = (SEL_W+1)'(NUM_MASTERS);
    localparam logic [SEL_W-1:0]   c_LAST  = SEL_W'(NUM_MASTERS - 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ADDR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   aw_sel_q, aw_sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [c_CNT_W-1:0] outstanding_q;

    logic [NUM_MASTERS-1:0] w_elig;
    logic                   w_win_found;
    logic [SEL_W-1:0]       w_win_idx;
    logic [SEL_W:0]         w_cand_sum;
    logic [SEL_W-1:0]       w_cand;
    logic                   w_aw_hs;

    // W-side index FIFO: master order of accepted addresses awaiting WLAST
    logic [SEL_W-1:0]   wf_mem_q [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0] wf_wr_q, wf_rd_q;
    logic [c_CNT_W-1:0] wf_cnt_q;
    logic               w_wf_push, w_wf_pop, w_wf_nempty;

    // B-side index FIFO: master order of completed bursts awaiting BRESP
    logic [SEL_W-1:0]   bf_mem_q [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0] bf_wr_q, bf_rd_q;
    logic [c_CNT_W-1:0] bf_cnt_q;
    logic               w_bf_push, w_bf_pop, w_bf_nempty;

`ifdef S3_WR_ARB_QOS_EN
    logic [3:0] w_max_qos;

    // Only requesters at the highest requested QoS level are eligible
    always_comb begin
        w_max_qos = 4'd0;
        w_elig    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_awvalid[i] && (m_awqos[i*4 +: 4] > w_max_qos)) begin
                w_max_qos = m_awqos[i*4 +: 4];
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_elig[i] = m_awvalid[i] && (m_awqos[i*4 +: 4] == w_max_qos);
        end
    end
`else
    assign w_elig = m_awvalid;
`endif

    // Round-robin search: first eligible requester at or after the pointer
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand_sum  = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_cand_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (w_cand_sum >= c_NUM_M) begin
                w_cand_sum = w_cand_sum - c_NUM_M;
            end
            w_cand = w_cand_sum[SEL_W-1:0];
            if (!w_win_found && w_elig[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    // FSM state, registered grant and round-robin pointer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= IDLE;
            aw_sel_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            aw_sel_q <= aw_sel_d;
            ptr_q    <= ptr_d;
        end
    end

    // Next-state: grant from IDLE when a slot is free, hold grant until AWREADY
    always_comb begin
        state_d  = state_q;
        aw_sel_d = aw_sel_q;
        ptr_d    = ptr_q;
        w_aw_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_win_found && (outstanding_q < c_MAX)) begin
                    state_d  = ADDR;
                    aw_sel_d = w_win_idx;
                end
            end
            ADDR: begin
                if (s_awready) begin
                    w_aw_hs = 1'b1;
                    state_d = IDLE;
                    ptr_d   = (aw_sel_q == c_LAST) ? '0 : aw_sel_q + SEL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_awvalid = (state_q == ADDR);
    assign aw_sel    = aw_sel_q;
    assign m_awready = (state_q == ADDR && s_awready) ? (NUM_MASTERS'(1) << aw_sel_q) : '0;

    // W FIFO control; a beat without WLAST leaves the head in place
    assign w_wf_nempty = (wf_cnt_q != '0);
    assign w_wf_push   = w_aw_hs;
    assign w_wf_pop    = s_wvalid && s_wready && s_wlast && w_wf_nempty;

    // W FIFO storage
    always_ff @(posedge ACLK) begin
        if (w_wf_push) begin
            wf_mem_q[wf_wr_q] <= aw_sel_q;
        end
    end

    // W FIFO pointers and occupancy
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wf_wr_q  <= '0;
            wf_rd_q  <= '0;
            wf_cnt_q <= '0;
        end else begin
            if (w_wf_push) wf_wr_q <= wf_wr_q + c_PTR_W'(1);
            if (w_wf_pop)  wf_rd_q <= wf_rd_q + c_PTR_W'(1);
            case ({w_wf_push, w_wf_pop})
                2'b10:   wf_cnt_q <= wf_cnt_q + c_CNT_W'(1);
                2'b01:   wf_cnt_q <= wf_cnt_q - c_CNT_W'(1);
                default: wf_cnt_q <= wf_cnt_q;
            endcase
        end
    end

    assign w_sel_valid = w_wf_nempty;
    assign w_sel       = w_wf_nempty ? wf_mem_q[wf_rd_q] : '0;

    // B FIFO control; BVALID with nothing pending is ignored
    assign w_bf_nempty = (bf_cnt_q != '0);
    assign w_bf_push   = w_wf_pop;
    assign w_bf_pop    = s_bvalid && s_bready && w_bf_nempty;

    // B FIFO storage
    always_ff @(posedge ACLK) begin
        if (w_bf_push) begin
            bf_mem_q[bf_wr_q] <= wf_mem_q[wf_rd_q];
        end
    end

    // B FIFO pointers and occupancy
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bf_wr_q  <= '0;
            bf_rd_q  <= '0;
            bf_cnt_q <= '0;
        end else begin
            if (w_bf_push) bf_wr_q <= bf_wr_q + c_PTR_W'(1);
            if (w_bf_pop)  bf_rd_q <= bf_rd_q + c_PTR_W'(1);
            case ({w_bf_push, w_bf_pop})
                2'b10:   bf_cnt_q <= bf_cnt_q + c_CNT_W'(1);
                2'b01:   bf_cnt_q <= bf_cnt_q - c_CNT_W'(1);
                default: bf_cnt_q <= bf_cnt_q;
            endcase
        end
    end

    assign b_sel_valid = w_bf_nempty;
    assign b_sel       = w_bf_nempty ? bf_mem_q[bf_rd_q] : '0;

    // Outstanding writes: +1 on AW accept, -1 on B completion
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            outstanding_q <= '0;
        end else begin
            case ({w_aw_hs, w_bf_pop})
                2'b10:   outstanding_q <= outstanding_q + c_CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - c_CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign outstanding = outstanding_q;

endmodule
`default_nettype wire

// File: tb/tb_s3_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s3_wr_arbiter
//  Brief    : Self-checking bench for s3_wr_arbiter. Expected AW grants and
//             B-steering indices are queued as stimulus is applied and
//             compared when the handshakes occur.
//  Revision : 1.0  initial release
// ============================================================================
module tb_s3_wr_arbiter;

    localparam int NM = 4;
    localparam int SW = 2;
    localparam int MO = 4;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [NM-1:0] m_awvalid = '0;
`ifdef S3_WR_ARB_QOS_EN
    logic [NM*4-1:0] m_awqos = '0;
`endif
    logic [NM-1:0] m_awready;
    logic          s_awvalid;
    logic          s_awready = 1'b0;
    logic [SW-1:0] aw_sel, w_sel, b_sel;
    logic          w_sel_valid, b_sel_valid;
    logic          s_wvalid = 1'b0, s_wready = 1'b0, s_wlast = 1'b0;
    logic          s_bvalid = 1'b0, s_bready = 1'b0;
    logic [2:0]    outstanding;

    int errors = 0;
    int checks = 0;
    int aw_q[$];
    int b_q[$];
    int grant_cnt[NM];
    int mon_e;
    logic [NM-1:0] mon_oh;

    s3_wr_arbiter #(.NUM_MASTERS(NM), .SEL_W(SW), .MAX_OUTSTANDING(MO)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .m_awvalid   (m_awvalid),
`ifdef S3_WR_ARB_QOS_EN
        .m_awqos     (m_awqos),
`endif
        .m_awready   (m_awready),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .aw_sel      (aw_sel),
        .w_sel       (w_sel),
        .w_sel_valid (w_sel_valid),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_wlast     (s_wlast),
        .b_sel       (b_sel),
        .b_sel_valid (b_sel_valid),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .outstanding (outstanding)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard: compare each AW and B handshake against the queued expectation
    always @(negedge ACLK) begin
        if (!ARESET && s_awvalid && s_awready) begin
            checks++;
            if (aw_q.size() == 0) begin
                errors++;
                $display("FAIL aw_unexpected: aw_sel=%0d granted, no grant expected", aw_sel);
            end else begin
                mon_e  = aw_q.pop_front();
                mon_oh = 4'b0001 << mon_e;
                if (aw_sel !== SW'(mon_e)) begin
                    errors++;
                    $display("FAIL aw_order: aw_sel=%0d expected %0d", aw_sel, mon_e);
                end
                checks++;
                if (m_awready !== mon_oh) begin
                    errors++;
                    $display("FAIL aw_ready: m_awready=%b expected %b", m_awready, mon_oh);
                end
                grant_cnt[aw_sel]++;
            end
        end
        if (!ARESET && s_bvalid && s_bready && b_sel_valid) begin
            checks++;
            if (b_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: b_sel=%0d popped, no B expected", b_sel);
            end else begin
                mon_e = b_q.pop_front();
                if (b_sel !== SW'(mon_e)) begin
                    errors++;
                    $display("FAIL b_order: b_sel=%0d expected %0d", b_sel, mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET    = 1'b1;
        m_awvalid = '0;
        s_awready = 1'b0;
        s_wvalid  = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
        s_bvalid  = 1'b0; s_bready = 1'b0;
        step();
        step();
        aw_q.delete();
        b_q.delete();
        for (int i = 0; i < NM; i++) grant_cnt[i] = 0;
        ARESET = 1'b0;
    endtask

    // Step until at most 'remain' expected grants are left, bounded
    task automatic wait_aw(input int remain, output bit ok);
        int n;
        n = 0;
        while (aw_q.size() > remain && n < 60) begin
            step();
            n++;
        end
        ok = (aw_q.size() <= remain);
    endtask

    task automatic test_reset();
        ARESET    = 1'b1;
        m_awvalid = 4'hF;
        s_awready = 1'b1;
        s_bvalid  = 1'b1; s_bready = 1'b1;
        step();
        step();
        @(negedge ACLK);
        checks++;
        if ({s_awvalid, m_awready, aw_sel} !== '0) begin
            errors++;
            $display("FAIL reset_aw: awvalid=%b awready=%b aw_sel=%0d expected all 0", s_awvalid, m_awready, aw_sel);
        end
        checks++;
        if ({w_sel_valid, w_sel, b_sel_valid, b_sel, outstanding} !== '0) begin
            errors++;
            $display("FAIL reset_fifo: wv=%b w_sel=%0d bv=%b b_sel=%0d outstanding=%0d expected all 0",
                     w_sel_valid, w_sel, b_sel_valid, b_sel, outstanding);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        m_awvalid = 4'b0100;
        s_awready = 1'b1;
        aw_q.push_back(2);
        @(negedge ACLK);
        checks++;
        if (s_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: s_awvalid=%b expected 0 in request cycle", s_awvalid);
        end
        step();
        @(negedge ACLK);
        checks++;
        if (s_awvalid !== 1'b1 || aw_sel !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: s_awvalid=%b aw_sel=%0d expected 1 / 2", s_awvalid, aw_sel);
        end
        step();
        m_awvalid = '0;
        @(negedge ACLK);
        checks++;
        if (outstanding !== 3'd1) begin
            errors++;
            $display("FAIL single_outstanding: outstanding=%0d expected 1", outstanding);
        end
        checks++;
        if (w_sel !== 2'd2 || w_sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_wsel: w_sel=%0d valid=%b expected 2 / 1", w_sel, w_sel_valid);
        end
        checks++;
        if (m_awready !== 4'b0000 || aw_q.size() != 0) begin
            errors++;
            $display("FAIL single_once: m_awready=%b pending=%0d expected 0000 / 0", m_awready, aw_q.size());
        end
    endtask

    task automatic test_round_robin();
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        int cnt_exp[NM] = '{2, 1, 1, 1};
        bit ok;
        do_reset();
        s_awready = 1'b1;
        s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = 1'b1;
        s_bvalid = 1'b1; s_bready = 1'b1;
        foreach (rr_exp[i]) begin
            aw_q.push_back(rr_exp[i]);
            b_q.push_back(rr_exp[i]);
        end
        m_awvalid = 4'hF;
        wait_aw(0, ok);
        m_awvalid = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_timeout: %0d grants still pending, expected 0", aw_q.size());
        end
        repeat (4) step();
        @(negedge ACLK);
        checks++;
        if (b_q.size() != 0 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL rr_drain: pending B=%0d outstanding=%0d expected 0 / 0", b_q.size(), outstanding);
        end
        for (int i = 0; i < NM; i++) begin
            checks++;
            if (grant_cnt[i] != cnt_exp[i]) begin
                errors++;
                $display("FAIL rr_count: master %0d granted %0d times expected %0d", i, grant_cnt[i], cnt_exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        m_awvalid = 4'b0001;
        s_awready = 1'b0;
        aw_q.push_back(0);
        aw_q.push_back(2);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) m_awvalid = 4'b0101;
            @(negedge ACLK);
            checks++;
            if (s_awvalid !== 1'b1 || aw_sel !== 2'd0 || m_awready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold: awvalid=%b aw_sel=%0d awready=%b expected 1 / 0 / 0000",
                         s_awvalid, aw_sel, m_awready);
            end
        end
        step();
        s_awready = 1'b1;
        step();
        m_awvalid = 4'b0100;
        wait_aw(0, ok);
        m_awvalid = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_timeout: %0d grants still pending, expected 0", aw_q.size());
        end
        @(negedge ACLK);
        checks++;
        if (outstanding !== 3'd2) begin
            errors++;
            $display("FAIL stall_outstanding: outstanding=%0d expected 2", outstanding);
        end
    endtask

    task automatic test_full();
        int f_exp[5] = '{0, 1, 2, 3, 0};
        bit ok;
        do_reset();
        s_awready = 1'b1;
        foreach (f_exp[i]) aw_q.push_back(f_exp[i]);
        b_q.push_back(0);
        m_awvalid = 4'hF;
        wait_aw(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_timeout: %0d grants still pending, expected 1", aw_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge ACLK);
            checks++;
            if (s_awvalid !== 1'b0 || m_awready !== 4'b0000 || outstanding !== 3'd4) begin
                errors++;
                $display("FAIL full_block: awvalid=%b awready=%b outstanding=%0d expected 0 / 0000 / 4",
                         s_awvalid, m_awready, outstanding);
            end
        end
        step();
        s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = 1'b1;
        step();
        s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
        s_bvalid = 1'b1; s_bready = 1'b1;
        step();
        s_bvalid = 1'b0; s_bready = 1'b0;
        @(negedge ACLK);
        checks++;
        if (outstanding !== 3'd3 || b_q.size() != 0) begin
            errors++;
            $display("FAIL full_release: outstanding=%0d pending B=%0d expected 3 / 0", outstanding, b_q.size());
        end
        step();
        @(negedge ACLK);
        checks++;
        if (s_awvalid !== 1'b1 || aw_sel !== 2'd0) begin
            errors++;
            $display("FAIL full_regrant: awvalid=%b aw_sel=%0d expected 1 / 0", s_awvalid, aw_sel);
        end
        step();
        m_awvalid = '0;
        @(negedge ACLK);
        checks++;
        if (aw_q.size() != 0 || outstanding !== 3'd4) begin
            errors++;
            $display("FAIL full_refill: pending=%0d outstanding=%0d expected 0 / 4", aw_q.size(), outstanding);
        end
    endtask

    task automatic test_order();
        bit ok;
        do_reset();
        s_awready = 1'b1;
        aw_q.push_back(1); aw_q.push_back(3);
        b_q.push_back(1);  b_q.push_back(3);
        m_awvalid = 4'b1010;
        wait_aw(0, ok);
        m_awvalid = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL order_timeout: %0d grants still pending, expected 0", aw_q.size());
        end
        step();
        // stray BVALID with no completed burst must be ignored
        s_bvalid = 1'b1; s_bready = 1'b1;
        step();
        s_bvalid = 1'b0; s_bready = 1'b0;
        @(negedge ACLK);
        checks++;
        if (outstanding !== 3'd2 || b_sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_stray_b: outstanding=%0d b_sel_valid=%b expected 2 / 0", outstanding, b_sel_valid);
        end
        s_wready = 1'b1;
        for (int beat = 0; beat < 4; beat++) begin
            s_wvalid = 1'b1;
            s_wlast  = (beat == 3);
            @(negedge ACLK);
            checks++;
            if (w_sel !== 2'd1 || w_sel_valid !== 1'b1) begin
                errors++;
                $display("FAIL order_burst: beat %0d w_sel=%0d valid=%b expected 1 / 1", beat, w_sel, w_sel_valid);
            end
            step();
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        @(negedge ACLK);
        checks++;
        if (w_sel !== 2'd3 || w_sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL order_next: w_sel=%0d valid=%b expected 3 / 1", w_sel, w_sel_valid);
        end
        s_wvalid = 1'b1; s_wlast = 1'b1;
        step();
        s_wvalid = 1'b0; s_wlast = 1'b0;
        m_awvalid = 4'b0001;
        aw_q.push_back(0);
        step();
        s_bvalid = 1'b1; s_bready = 1'b1;
        @(negedge ACLK);
        checks++;
        if (s_awvalid !== 1'b1 || outstanding !== 3'd2) begin
            errors++;
            $display("FAIL order_pre_sim: awvalid=%b outstanding=%0d expected 1 / 2", s_awvalid, outstanding);
        end
        step();
        m_awvalid = '0;
        @(negedge ACLK);
        checks++;
        if (outstanding !== 3'd2) begin
            errors++;
            $display("FAIL order_simul: outstanding=%0d expected 2 after AW push + B pop", outstanding);
        end
        step();
        s_bvalid = 1'b0; s_bready = 1'b0;
        @(negedge ACLK);
        checks++;
        if (outstanding !== 3'd1 || b_q.size() != 0 || aw_q.size() != 0) begin
            errors++;
            $display("FAIL order_final: outstanding=%0d pending B=%0d pending AW=%0d expected 1 / 0 / 0",
                     outstanding, b_q.size(), aw_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        s_awready = 1'b1;
        aw_q.push_back(0); aw_q.push_back(1);
        m_awvalid = 4'b0011;
        wait_aw(0, ok);
        m_awvalid = '0;
        s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = 1'b0;
        step();
        @(negedge ACLK);
        checks++;
        if (!ok || outstanding !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_setup: ok=%b outstanding=%0d expected 1 / 2", ok, outstanding);
        end
        ARESET = 1'b1;
        s_wvalid = 1'b0; s_wready = 1'b0;
        step();
        @(negedge ACLK);
        checks++;
        if ({s_awvalid, m_awready, aw_sel, w_sel_valid, w_sel, b_sel_valid, b_sel, outstanding} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: awv=%b awr=%b aw=%0d wv=%b w=%0d bv=%b b=%0d out=%0d expected all 0",
                     s_awvalid, m_awready, aw_sel, w_sel_valid, w_sel, b_sel_valid, b_sel, outstanding);
        end
        step();
        ARESET = 1'b0;
        aw_q.delete();
        aw_q.push_back(1); aw_q.push_back(3);
        m_awvalid = 4'b1010;
        wait_aw(0, ok);
        m_awvalid = '0;
        step();
        @(negedge ACLK);
        checks++;
        if (!ok || outstanding !== 3'd2 || w_sel !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_regrant: ok=%b outstanding=%0d w_sel=%0d expected 1 / 2 / 1", ok, outstanding, w_sel);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_full();
        test_order();
        test_reset_mid();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s3_wr_arbiter.md
Name: s3_wr_arbiter

Overview:
- Write-path arbiter for Slave 3 in the 4-master / 7-slave AXI interconnect.
- Shares the S3 write address channel between NUM_MASTERS requesters using round-robin arbitration.
- Records grant order so it can steer the external W-data mux and B-response demux in the same order.
- Control only: AW/W/B payload muxing is done by external datapath driven by aw_sel / w_sel / b_sel.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
SEL_W, 2, width of the master index; equals clog2(NUM_MASTERS)
MAX_OUTSTANDING, 4, maximum writes accepted on AW but not yet completed on B; power of 2, 2..16

Ports:
ACLK  input  1  clock, all logic on posedge
ARESET  input  1  synchronous, active-high reset
m_awvalid  input  NUM_MASTERS  per-master AW request, already decoded to target S3
m_awready  output  NUM_MASTERS  per-master AW accept
s_awvalid  output  1  S3_AWVALID toward slave
s_awready  input  1  S3_AWREADY from slave
aw_sel  output  SEL_W  AW payload mux select
w_sel  output  SEL_W  W mux select (master owning current burst)
w_sel_valid  output  1  W mux enable; W beats pass only while high
s_wvalid  input  1  S3_WVALID, post-mux
s_wready  input  1  S3_WREADY
s_wlast  input  1  S3_WLAST, post-mux
b_sel  output  SEL_W  B demux select
b_sel_valid  output  1  B demux enable
s_bvalid  input  1  S3_BVALID
s_bready  input  1  S3_BREADY, post-demux
outstanding  output  clog2(MAX_OUTSTANDING)+1  current outstanding write count

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0, both FIFOs empty, outstanding 0. Reset mid-burst discards every in-flight entry.
- FSM has two states, IDLE and ADDR.
- IDLE -> ADDR when any m_awvalid is high and outstanding < MAX_OUTSTANDING.
  - Winner is the first requester at or after the pointer, searching in modulo order.
  - aw_sel is registered with the winner; s_awvalid goes high one cycle after the request is seen (latency 1).
- In ADDR:
  - s_awvalid=1; m_awready[aw_sel] = s_awready (combinational); all other m_awready = 0.
  - aw_sel is held stable until s_awready is seen (AXI stability rule).
  - A drop of m_awvalid[aw_sel] while in ADDR is a protocol violation; behaviour is undefined and has no requirement.
- AW handshake (s_awvalid & s_awready):
  - push aw_sel into the W FIFO; outstanding += 1;
  - pointer <= aw_sel+1 (mod NUM_MASTERS); FSM -> IDLE.
- One AW grant per two cycles at most; no back-to-back re-grant in the same cycle.
- W FIFO (depth MAX_OUTSTANDING):
  - w_sel = head entry; w_sel_valid = not empty.
  - Pop on s_wvalid & s_wready & s_wlast, and push the popped index into the B FIFO.
  - A W handshake without WLAST does not pop.
- B FIFO (depth MAX_OUTSTANDING):
  - b_sel = head entry; b_sel_valid = not empty.
  - Pop on s_bvalid & s_bready; outstanding -= 1.
  - S3 returns B in AW order (single-ID slave), so in-order steering is correct.
- Simultaneous events:
  - AW push and B pop in the same cycle leave outstanding unchanged.
  - Push and pop on the same FIFO in one cycle are both performed; count unchanged.
- Full boundary:
  - outstanding == MAX_OUTSTANDING blocks the IDLE->ADDR transition.
  - Requesters see m_awready=0 indefinitely until a B completes.
  - Neither FIFO can overflow, because the sum of entries never exceeds outstanding.
- Empty boundary:
  - W beats arriving with the W FIFO empty are blocked externally (w_sel_valid=0).
  - s_bvalid with the B FIFO empty is a slave error: ignored, no pop, outstanding not decremented.
- Pointer wraps from NUM_MASTERS-1 to 0.
- outstanding never underflows below 0.

Optional Feature:
- Macro S3_WR_ARB_QOS_EN.
- Defined:
  - adds input port m_awqos, width NUM_MASTERS*4, slice i belongs to master i;
  - the winner is the requester with the highest QoS;
  - ties among equal-highest QoS are resolved round-robin from the pointer;
  - the pointer is updated exactly as in the base mode.
- Undefined: port absent, pure round-robin.

Test Plan:
- Reset then single request: m_awvalid=4'b0100, s_awready=1 -> aw_sel=2 and s_awvalid=1 one cycle later; m_awready=4'b0100 for one cycle; outstanding=1; w_sel=2 with w_sel_valid=1.
- All four requesting continuously, s_awready=1, W/B completing immediately -> grant order 0,1,2,3,0 with pointer wrap; each master granted exactly once per 4 grants.
- Slave stall: s_awready=0 for 5 cycles while another master raises its request -> aw_sel and s_awvalid held constant; no m_awready asserted; grant issued on the first s_awready=1.
- Full: 4 AW accepted, no W/B activity, 5th request pending -> outstanding=4 and s_awvalid stays 0; after one WLAST beat and one B handshake, outstanding=3 and the 5th request is granted next cycle.
- Ordering and simultaneity: grants to masters 1 then 3, a 4-beat burst for master 1 (w_sel=1 until WLAST), then w_sel=3; a B handshake and the 3rd AW handshake in the same cycle leave outstanding unchanged; b_sel order is 1,3.
- Reset asserted mid-burst with outstanding=2 -> next cycle all outputs 0 and FIFOs empty; a new request from master 3 is granted with pointer 0.
